// File: rtl/sample_packer.sv
// ---------------------------------------------------------------------------
// sample_packer
//
// Gathers a serial stream of DATA_WIDTH-bit samples into one
// NUM_INPUTS*DATA_WIDTH parallel vector for the pipelined adder tree. Slot k
// of the vector occupies bits k*DATA_WIDTH +: DATA_WIDTH. An optional
// frame-start marker (sync_in) realigns the slot counter. A partial frame that
// is cut short by sync_in is discarded and flagged.
//
// Ports:
//   clk        single clock domain
//   rst        asynchronous, active-high reset
//   valid_in   data_in carries a sample this cycle
//   data_in    input sample
//   sync_in    frame-start marker; a sample qualified in the same cycle
//              becomes slot 0
//   data_out   last completed frame, held until the next completion
//   valid_out  one-cycle strobe: data_out holds a newly completed frame
//   drop_out   one-cycle strobe: a partial frame was discarded by sync_in
//   busy_out   partial frame in progress (slot counter nonzero)
// ---------------------------------------------------------------------------
module sample_packer #(
  parameter int NUM_INPUTS   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int REQUIRE_SYNC = 0,
  parameter int CNT_WIDTH    = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             sync_in,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  output logic                             drop_out,
  output logic                             busy_out
);

  generate
    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("sample_packer: NUM_INPUTS must be >= 2");
    end
  endgenerate

  localparam logic [0:0] WAIT_SYNC = 1'b0;
  localparam logic [0:0] FILL      = 1'b1;

  localparam logic [0:0] RESET_STATE = (REQUIRE_SYNC != 0) ? WAIT_SYNC : FILL;
  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(NUM_INPUTS - 1);

  logic [0:0]                       state;
  logic [0:0]                       state_next;
  logic [CNT_WIDTH-1:0]             cnt;
  logic [CNT_WIDTH-1:0]             cnt_next;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] collect;
  logic                             wr_en;
  logic [CNT_WIDTH-1:0]             wr_slot;
  logic                             complete;
  logic                             complete_pend;
  logic                             drop;

  // Next-state / slot-write decision. sync_in takes priority over frame
  // completion, so a sync on the last slot drops the partial frame instead of
  // finishing it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    wr_slot    = cnt;
    complete   = 1'b0;
    drop       = 1'b0;
    if (sync_in) begin
      state_next = FILL;
      // In WAIT_SYNC the counter is always 0, so this only fires in FILL.
      drop = (state == FILL) && (cnt != '0);
      if (valid_in) begin
        wr_en    = 1'b1;
        wr_slot  = '0;
        cnt_next = CNT_WIDTH'(1);
      end else begin
        cnt_next = '0;
      end
    end else if ((state == FILL) && valid_in) begin
      wr_en = 1'b1;
      if (cnt == LAST_SLOT) begin
        cnt_next = '0;
        complete = 1'b1;
      end else begin
        cnt_next = cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Completion is registered once (complete_pend) and published on the
  // following edge. The collect register may already take slot 0 of the next
  // frame on that same edge; the nonblocking copy still sees the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RESET_STATE;
      cnt           <= '0;
      collect       <= '0;
      data_out      <= '0;
      complete_pend <= 1'b0;
      valid_out     <= 1'b0;
      drop_out      <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (wr_en && (wr_slot == CNT_WIDTH'(k))) begin
          collect[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
        end
      end
      complete_pend <= complete;
      valid_out     <= complete_pend;
      if (complete_pend) begin
        data_out <= collect;
      end
      drop_out <= drop;
      busy_out <= (cnt_next != '0);
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_sample_packer
//
// Directed bench for sample_packer with NUM_INPUTS=4, DATA_WIDTH=16.
// dut0 runs with REQUIRE_SYNC=0, dut1 with REQUIRE_SYNC=1; both share clk/rst.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. A table row holds one cycle of inputs and the outputs
// expected just after the rising edge that ends that cycle.
// ---------------------------------------------------------------------------
module tb_sample_packer;

  localparam int N = 4;
  localparam int W = 16;

  localparam logic [N*W-1:0] F1 = 64'h0004_0003_0002_0001;
  localparam logic [N*W-1:0] F2 = 64'h0008_0007_0006_0005;
  localparam logic [N*W-1:0] F3 = 64'h000D_000C_000B_000A;
  localparam logic [N*W-1:0] F4 = 64'h0006_0007_0008_0009;
  localparam logic [N*W-1:0] F5 = 64'h0034_0033_0032_0031;
  localparam logic [N*W-1:0] F6 = 64'h0044_0033_0022_0011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           v0, s0, v1, s1;
  logic [W-1:0]   d0, d1;
  logic [N*W-1:0] dout0, dout1;
  logic           vo0, dr0, b0, vo1, dr1, b1;

  sample_packer #(.NUM_INPUTS(N), .DATA_WIDTH(W), .REQUIRE_SYNC(0)) dut0 (
    .clk(clk), .rst(rst), .valid_in(v0), .data_in(d0), .sync_in(s0),
    .data_out(dout0), .valid_out(vo0), .drop_out(dr0), .busy_out(b0)
  );

  sample_packer #(.NUM_INPUTS(N), .DATA_WIDTH(W), .REQUIRE_SYNC(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(v1), .data_in(d1), .sync_in(s1),
    .data_out(dout1), .valid_out(vo1), .drop_out(dr1), .busy_out(b1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic           v;
    logic           s;
    logic [W-1:0]   d;
    logic           ev;
    logic           ed;
    logic           eb;
    logic [N*W-1:0] edat;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic v, input logic s, input logic [W-1:0] d,
                     input logic ev, input logic ed, input logic eb,
                     input logic [N*W-1:0] edat);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.ev = ev; r.ed = ed; r.eb = eb; r.edat = edat;
    tab.push_back(r);
  endtask

  // One cycle on dut0: drive at the falling edge, sample after the rising edge.
  task automatic step0(input logic v, input logic s, input logic [W-1:0] d);
    v0 = v; s0 = s; d0 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic v, input logic s, input logic [W-1:0] d);
    v1 = v; s1 = s; d1 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic ev, input logic ed,
                      input logic eb, input logic [N*W-1:0] edat);
    chk({tag, ".valid"}, N*W'(vo0), N*W'(ev));
    chk({tag, ".drop"},  N*W'(dr0), N*W'(ed));
    chk({tag, ".busy"},  N*W'(b0),  N*W'(eb));
    chk({tag, ".data"},  dout0,     edat);
  endtask

  task automatic chk1(input string tag, input logic ev, input logic ed,
                      input logic eb, input logic [N*W-1:0] edat);
    chk({tag, ".valid"}, N*W'(vo1), N*W'(ev));
    chk({tag, ".drop"},  N*W'(dr1), N*W'(ed));
    chk({tag, ".busy"},  N*W'(b1),  N*W'(eb));
    chk({tag, ".data"},  dout1,     edat);
  endtask

  initial begin
    //   v  s  data      valid drop busy data_out
    // basic frame
    add(1, 0, 16'h0001, 0, 0, 1, '0);
    add(1, 0, 16'h0002, 0, 0, 1, '0);
    add(1, 0, 16'h0003, 0, 0, 1, '0);
    add(1, 0, 16'h0004, 0, 0, 0, '0);
    add(0, 0, 16'h0000, 1, 0, 0, F1);
    add(0, 0, 16'h0000, 0, 0, 0, F1);
    // back-to-back frames
    add(1, 0, 16'h0001, 0, 0, 1, F1);
    add(1, 0, 16'h0002, 0, 0, 1, F1);
    add(1, 0, 16'h0003, 0, 0, 1, F1);
    add(1, 0, 16'h0004, 0, 0, 0, F1);
    add(1, 0, 16'h0005, 1, 0, 1, F1);
    add(1, 0, 16'h0006, 0, 0, 1, F1);
    add(1, 0, 16'h0007, 0, 0, 1, F1);
    add(1, 0, 16'h0008, 0, 0, 0, F1);
    add(0, 0, 16'h0000, 1, 0, 0, F2);
    add(0, 0, 16'h0000, 0, 0, 0, F2);
    // gapped input
    add(1, 0, 16'h000A, 0, 0, 1, F2);
    add(1, 0, 16'h000B, 0, 0, 1, F2);
    add(0, 0, 16'h00FF, 0, 0, 1, F2);
    add(0, 0, 16'h00FF, 0, 0, 1, F2);
    add(0, 0, 16'h00FF, 0, 0, 1, F2);
    add(1, 0, 16'h000C, 0, 0, 1, F2);
    add(1, 0, 16'h000D, 0, 0, 0, F2);
    add(0, 0, 16'h0000, 1, 0, 0, F3);
    // mid-frame resync with a sample
    add(1, 0, 16'h0001, 0, 0, 1, F3);
    add(1, 0, 16'h0002, 0, 0, 1, F3);
    add(1, 1, 16'h0009, 0, 1, 1, F3);
    add(1, 0, 16'h0008, 0, 0, 1, F3);
    add(1, 0, 16'h0007, 0, 0, 1, F3);
    add(1, 0, 16'h0006, 0, 0, 0, F3);
    add(0, 0, 16'h0000, 1, 0, 0, F4);
    // sync while idle: no drop
    add(0, 1, 16'h0000, 0, 0, 0, F4);
    // sync+valid on the last slot drops instead of completing
    add(1, 0, 16'h0021, 0, 0, 1, F4);
    add(1, 0, 16'h0022, 0, 0, 1, F4);
    add(1, 0, 16'h0023, 0, 0, 1, F4);
    add(1, 1, 16'h0031, 0, 1, 1, F4);
    add(1, 0, 16'h0032, 0, 0, 1, F4);
    add(1, 0, 16'h0033, 0, 0, 1, F4);
    add(1, 0, 16'h0034, 0, 0, 0, F4);
    add(0, 0, 16'h0000, 1, 0, 0, F5);
    // sync without a sample mid-frame
    add(1, 0, 16'h0041, 0, 0, 1, F5);
    add(0, 1, 16'h0000, 0, 1, 0, F5);
    add(0, 0, 16'h0000, 0, 0, 0, F5);

    v0 = 0; s0 = 0; d0 = '0;
    v1 = 0; s1 = 0; d1 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk0("reset0", 0, 0, 0, '0);
    chk1("reset1", 0, 0, 0, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      step0(tab[i].v, tab[i].s, tab[i].d);
      chk0($sformatf("row%0d", i), tab[i].ev, tab[i].ed, tab[i].eb, tab[i].edat);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a frame
    step0(1, 0, 16'h0005); chk0("ar_a", 0, 0, 1, F5); @(negedge clk);
    step0(1, 0, 16'h0006); chk0("ar_b", 0, 0, 1, F5); @(negedge clk);
    step0(1, 0, 16'h0007); chk0("ar_c", 0, 0, 1, F5); @(negedge clk);
    v0 = 0; d0 = '0;
    #2 rst = 1'b1;
    #1 chk0("ar_imm", 0, 0, 0, '0);
    @(posedge clk);
    #1 chk0("ar_hold", 0, 0, 0, '0);
    @(negedge clk);
    rst = 1'b0;
    step0(1, 0, 16'h0005); chk0("ar_d", 0, 0, 1, '0); @(negedge clk);
    step0(1, 0, 16'h0006); chk0("ar_e", 0, 0, 1, '0); @(negedge clk);
    step0(1, 0, 16'h0007); chk0("ar_f", 0, 0, 1, '0); @(negedge clk);
    step0(1, 0, 16'h0008); chk0("ar_g", 0, 0, 0, '0); @(negedge clk);
    step0(0, 0, 16'h0000); chk0("ar_h", 1, 0, 0, F2); @(negedge clk);
    step0(0, 0, 16'h0000); chk0("ar_i", 0, 0, 0, F2); @(negedge clk);

    // REQUIRE_SYNC=1: samples before the first sync are ignored
    for (int i = 0; i < 5; i++) begin
      step1(1, 0, W'(16'h0050 + i));
      chk1($sformatf("rs_pre%0d", i), 0, 0, 0, '0);
      @(negedge clk);
    end
    step1(1, 1, 16'h0011); chk1("rs_a", 0, 0, 1, '0); @(negedge clk);
    step1(1, 0, 16'h0022); chk1("rs_b", 0, 0, 1, '0); @(negedge clk);
    step1(1, 0, 16'h0033); chk1("rs_c", 0, 0, 1, '0); @(negedge clk);
    step1(1, 0, 16'h0044); chk1("rs_d", 0, 0, 0, '0); @(negedge clk);
    step1(0, 0, 16'h0000); chk1("rs_e", 1, 0, 0, F6); @(negedge clk);
    step1(0, 0, 16'h0000); chk1("rs_f", 0, 0, 0, F6); @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Producer-side companion to the pipelined adder tree: gathers a serial stream of DATA_WIDTH samples into one NUM_INPUTS*DATA_WIDTH parallel vector with a single-cycle valid strobe.
- Output lane order matches the tree input: slot k occupies bits k*DATA_WIDTH +: DATA_WIDTH.
- Frame alignment comes from an optional sync marker. Misaligned partial frames are discarded and flagged.

Parameters:
- NUM_INPUTS, 10, samples per output vector; must be >= 2 (elaborate-time error otherwise).
- DATA_WIDTH, 16, bits per sample; passed through unchanged, no arithmetic on data.
- REQUIRE_SYNC, 0, 1 = ignore samples after reset until the first sync_in; 0 = start packing immediately.
- CNT_WIDTH, $clog2(NUM_INPUTS), derived slot-counter width; do not override.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  data_in carries a sample this cycle.
- data_in  in  DATA_WIDTH  input sample.
- sync_in  in  1  frame-start marker; a sample qualified in the same cycle becomes slot 0.
- data_out  out  NUM_INPUTS*DATA_WIDTH  last completed frame.
- valid_out  out  1  one-cycle strobe, data_out holds a newly completed frame.
- drop_out  out  1  one-cycle strobe, a partial frame was discarded by sync_in.
- busy_out  out  1  slot counter nonzero (partial frame in progress).

Behaviour:
- Reset (async assert, sync release):
  - slot counter = 0; collect and output registers = 0; valid_out = drop_out = busy_out = 0.
  - State = WAIT_SYNC if REQUIRE_SYNC = 1, else FILL.
  - Reset mid-frame discards the partial frame with no drop_out pulse.
- State WAIT_SYNC:
  - valid_in without sync_in is ignored.
  - sync_in moves the block to FILL. If valid_in is also high, that sample is written to slot 0 and the counter becomes 1; otherwise the counter stays 0.
- State FILL, valid_in and no sync_in:
  - Sample is written to collect slot cnt; cnt increments.
  - On cnt == NUM_INPUTS-1, cnt wraps to 0. The next cycle, the collect vector including this sample is copied to data_out and valid_out = 1 for exactly one cycle.
- Latency: valid_out rises on the clock edge after the edge that captures the last sample, i.e. 1 cycle.
- Throughput: back-to-back frames at one sample per cycle, no gaps. The collect register refills while data_out holds the previous frame.
- data_out is stable from one valid_out to the next. Gaps in valid_in only stall the counter.
- sync_in in FILL:
  - If cnt != 0, drop_out = 1 on the next cycle and the partial samples never appear on data_out.
  - The counter restarts: to 1 with the sample in slot 0 if valid_in is high, else to 0.
  - sync_in while cnt == 0 does not pulse drop_out.
- sync_in together with valid_in at cnt == NUM_INPUTS-1 does not complete the frame: the old partial frame is dropped and the new sample becomes slot 0.
- Stale slots in the collect register are not cleared between frames; every slot is overwritten before the next valid_out.
- busy_out = (cnt != 0), registered.
- valid_out and drop_out are never high together, because a completion and a drop cannot occur in the same cycle.

Test Plan:
- Basic frame (NUM_INPUTS=4, DATA_WIDTH=16, REQUIRE_SYNC=0): samples 1,2,3,4 on consecutive cycles.
  - Expect valid_out for one cycle, 1 cycle after sample 4.
  - Expect data_out = 0x0004_0003_0002_0001.
- Back-to-back: samples 1..8 continuous.
  - Expect two valid_out pulses 4 cycles apart, vectors 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005.
  - First vector held until the second strobe.
- Gapped input: samples 0xA,0xB, 3 idle cycles, then 0xC,0xD.
  - Expect a single valid_out after 0xD, data_out = 0x000D_000C_000B_000A, busy_out high during the gap.
- Mid-frame resync: samples 1,2, then sync_in+valid_in with 9, then 8,7,6.
  - Expect drop_out pulse 1 cycle after the sync, then valid_out with 0x0006_0007_0008_0009; no vector containing 1 or 2 appears.
- REQUIRE_SYNC=1: five samples before any sync, then sync+valid with 0x11 followed by 0x22,0x33,0x44.
  - Expect no valid_out before the sync, then data_out = 0x0044_0033_0022_0011.
- Async reset: rst asserted after 3 of 4 samples.
  - Expect all outputs 0 immediately, no drop_out.
  - After release, samples 5,6,7,8 give 0x0008_0007_0006_0005.
